// File: rtl/pop_router_if.sv
// Handshake bundle between pop_router, the upstream input FIFO and the four
// downstream lane FIFOs.
interface pop_router_if #(
   parameter int DATA_SIZE = 10
);
   logic                 fifo_empty;
   logic [DATA_SIZE-1:0] data_out_pop;
   logic                 read;
   logic [3:0]           lane_pause;
   logic [DATA_SIZE-1:0] push_data;
   logic [3:0]           push;

   // The router drives the pop strobe and the lane write side.
   modport master (
      input  fifo_empty,
      input  data_out_pop,
      input  lane_pause,
      output read,
      output push_data,
      output push
   );

   modport slave (
      output fifo_empty,
      output data_out_pop,
      output lane_pause,
      input  read,
      input  push_data,
      input  push
   );
endinterface

// File: rtl/pop_router.sv
// Pops words from the input FIFO, routes each to one of four lane FIFOs by its
// two top bits, stalls on the destination lane's pause and counts words per lane.
module pop_router #(
   parameter int DATA_SIZE = 10,
   parameter int CNT_SIZE  = 8
) (
   input  logic                clk,
   input  logic                reset,
   pop_router_if.master        bus,
   output logic                router_active,
   output logic [CNT_SIZE-1:0] cnt_lane0,
   output logic [CNT_SIZE-1:0] cnt_lane1,
   output logic [CNT_SIZE-1:0] cnt_lane2,
   output logic [CNT_SIZE-1:0] cnt_lane3
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SEND
   } state_t;

   state_t               state;
   logic [DATA_SIZE-1:0] hold;
   logic [CNT_SIZE-1:0]  cnt [4];
   logic [1:0]           dest;
   logic                 dest_ready;
   logic                 read_c;
   logic [3:0]           push_c;

   assign dest       = hold[DATA_SIZE-1 -: 2];
   assign dest_ready = !bus.lane_pause[dest];

   // Strobes are combinational so a pause edge gates the push in the same
   // cycle; reset masks them so nothing leaves while the datapath is cleared.
   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      read_c = 1'b0;
      push_c = 4'b0000;
      if (!reset) begin
         case (state)
            IDLE: read_c = !bus.fifo_empty;
            SEND: begin
               if (dest_ready) begin
                  push_c[dest] = 1'b1;
                  read_c       = !bus.fifo_empty;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: all state updates use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         hold  <= '0;
         // NOTE: the counters are only four registers and the tester reads them
         // straight after reset, so each one is cleared explicitly.
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (read_c) state <= FETCH;
            end
            FETCH: begin
               hold  <= bus.data_out_pop;
               state <= SEND;
            end
            SEND: begin
               if (dest_ready) begin
                  cnt[dest] <= cnt[dest] + 1'b1;
                  state     <= bus.fifo_empty ? IDLE : FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.read      = read_c;
   assign bus.push      = push_c;
   assign bus.push_data = hold;
   assign router_active = (state != IDLE);

   assign cnt_lane0 = cnt[0];
   assign cnt_lane1 = cnt[1];
   assign cnt_lane2 = cnt[2];
   assign cnt_lane3 = cnt[3];

endmodule

// File: tb/tb_pop_router.sv
// Directed bench for pop_router: behavioural upstream FIFO, push scoreboard
// and cycle-exact checks of latency, pause, counter wrap and reset.
module tb_pop_router;
   localparam int DS = 10;
   localparam int CS = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          router_active;
   logic [CS-1:0] cnt_lane0, cnt_lane1, cnt_lane2, cnt_lane3;

   pop_router_if #(.DATA_SIZE(DS)) bus ();

   pop_router #(.DATA_SIZE(DS), .CNT_SIZE(CS)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .router_active (router_active),
      .cnt_lane0     (cnt_lane0),
      .cnt_lane1     (cnt_lane1),
      .cnt_lane2     (cnt_lane2),
      .cnt_lane3     (cnt_lane3)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Upstream FIFO: data appears the cycle after read.
   logic [DS-1:0] mem [0:2047];
   int            wr_ptr = 0;
   int            rd_ptr = 0;

   assign bus.fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (bus.read) begin
         bus.data_out_pop <= mem[rd_ptr];
         rd_ptr           <= rd_ptr + 1;
      end
   end

   // Scoreboard entry: {one-hot lane, data}.
   logic [13:0] exp_q [$];
   logic [13:0] mon_e;

   always @(negedge clk) begin
      if (!reset) begin
         check("push_onehot", 32'($countones(bus.push) <= 1), 1);
         if (bus.push != 4'b0000) begin
            check("push_while_paused", bus.push & bus.lane_pause, 0);
            if (exp_q.size() == 0) begin
               check("unexpected_push", bus.push, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("sb_lane", bus.push, mon_e[13:10]);
               check("sb_data", bus.push_data, mon_e[9:0]);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic sample;
      @(negedge clk);
   endtask

   task automatic put_word(input logic [DS-1:0] w, input bit expect_it);
      logic [3:0] oh;
      mem[wr_ptr] = w;
      wr_ptr++;
      if (expect_it) begin
         oh = 4'd1 << w[DS-1 -: 2];
         exp_q.push_back({oh, w});
      end
   endtask

   task automatic do_reset;
      tick;
      reset          = 1'b1;
      bus.lane_pause = 4'b0000;
      tick;
      tick;
      wr_ptr = rd_ptr;
      exp_q.delete();
      reset = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         sample;
         done = (exp_q.size() == 0) && !router_active && bus.fifo_empty;
      end
      check("drain", done, 1);
      tick;
   endtask

   task automatic check_counts(input string tag, input logic [CS-1:0] c0, input logic [CS-1:0] c1,
                               input logic [CS-1:0] c2, input logic [CS-1:0] c3);
      check({tag, "_cnt0"}, cnt_lane0, c0);
      check({tag, "_cnt1"}, cnt_lane1, c1);
      check({tag, "_cnt2"}, cnt_lane2, c2);
      check({tag, "_cnt3"}, cnt_lane3, c3);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [3:0]    exp_push [10];
      logic          exp_read [10];
      logic [DS-1:0] w;

      reset          = 1'b1;
      bus.lane_pause = 4'b0000;
      tick;
      tick;
      sample;
      check("rst_read", bus.read, 0);
      check("rst_push", bus.push, 0);
      check("rst_active", router_active, 0);
      check("rst_push_data", bus.push_data, 0);
      check_counts("rst", 0, 0, 0, 0);
      tick;
      reset = 1'b0;

      // Single word to lane 0: read at c, push at c+2, idle at c+3.
      put_word(10'h0A5, 1'b1);
      sample;
      check("t1_read_c0", bus.read, 1);
      check("t1_push_c0", bus.push, 0);
      check("t1_active_c0", router_active, 0);
      tick;
      sample;
      check("t1_read_c1", bus.read, 0);
      check("t1_push_c1", bus.push, 0);
      check("t1_active_c1", router_active, 1);
      tick;
      sample;
      check("t1_push_c2", bus.push, 4'b0001);
      check("t1_data_c2", bus.push_data, 10'h0A5);
      check("t1_read_c2", bus.read, 0);
      tick;
      sample;
      check("t1_active_c3", router_active, 0);
      check_counts("t1", 1, 0, 0, 0);

      // Four queued words, back-to-back FETCH/SEND alternation.
      do_reset;
      exp_push = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
      exp_read = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      put_word(10'h123, 1'b1);
      put_word(10'h2FF, 1'b1);
      put_word(10'h0F0, 1'b1);
      put_word(10'h3AA, 1'b1);
      for (int i = 0; i < 10; i++) begin
         sample;
         check("t2_push", bus.push, exp_push[i]);
         check("t2_read", bus.read, exp_read[i]);
         tick;
      end
      sample;
      check_counts("t2", 1, 1, 1, 1);

      // Lane 2 paused for 5 SEND cycles, then released.
      do_reset;
      bus.lane_pause = 4'b0100;
      put_word(10'h201, 1'b1);
      tick;
      tick;
      for (int i = 0; i < 5; i++) begin
         sample;
         check("t3_paused_push", bus.push, 0);
         check("t3_paused_read", bus.read, 0);
         check("t3_paused_active", router_active, 1);
         check("t3_paused_data", bus.push_data, 10'h201);
         tick;
      end
      bus.lane_pause = 4'b0000;
      sample;
      check("t3_release_push", bus.push, 4'b0100);
      check("t3_release_data", bus.push_data, 10'h201);
      tick;
      sample;
      check_counts("t3a", 0, 0, 1, 0);
      tick;
      // Pause on another lane must not stall a lane-1 word.
      bus.lane_pause = 4'b0001;
      put_word(10'h1C3, 1'b1);
      tick;
      tick;
      sample;
      check("t3_other_pause_push", bus.push, 4'b0010);
      check("t3_other_pause_data", bus.push_data, 10'h1C3);
      tick;
      sample;
      check_counts("t3b", 0, 1, 1, 0);

      // 256 words to lane 3 wrap its counter to 0; one more gives 1.
      do_reset;
      for (int i = 0; i < 256; i++) begin
         w = {2'b11, 8'(i)};
         put_word(w, 1'b1);
      end
      wait_drain(700);
      check_counts("t4_wrap", 0, 0, 0, 0);
      put_word(10'h3C5, 1'b1);
      wait_drain(20);
      check_counts("t4_post", 0, 0, 0, 1);

      // Reset in FETCH discards the popped word.
      do_reset;
      put_word(10'h0A5, 1'b0);
      tick;
      reset = 1'b1;
      sample;
      check("t5a_push", bus.push, 0);
      check("t5a_read", bus.read, 0);
      tick;
      reset = 1'b0;
      sample;
      check("t5a_active", router_active, 0);
      check("t5a_data", bus.push_data, 0);
      check("t5a_push_after", bus.push, 0);
      check_counts("t5a", 0, 0, 0, 0);

      // Reset in a paused SEND wins over the pause dropping in the same cycle.
      tick;
      bus.lane_pause = 4'b0001;
      put_word(10'h0A5, 1'b0);
      tick;
      tick;
      sample;
      check("t5b_paused_push", bus.push, 0);
      check("t5b_paused_active", router_active, 1);
      tick;
      reset          = 1'b1;
      bus.lane_pause = 4'b0000;
      sample;
      check("t5b_rst_push", bus.push, 0);
      check("t5b_rst_read", bus.read, 0);
      tick;
      reset = 1'b0;
      sample;
      check("t5b_active", router_active, 0);
      check("t5b_data", bus.push_data, 0);
      check("t5b_push_after", bus.push, 0);
      check_counts("t5b", 0, 0, 0, 0);

      // Reset held with a non-empty FIFO keeps read low.
      tick;
      reset = 1'b1;
      put_word(10'h3FF, 1'b0);
      for (int i = 0; i < 3; i++) begin
         sample;
         check("t5c_read", bus.read, 0);
         check("t5c_push", bus.push, 0);
         tick;
      end
      wr_ptr = rd_ptr;
      reset  = 1'b0;
      sample;
      check("t5c_read_after", bus.read, 0);
      check("t5c_active_after", router_active, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pop_router.md
# pop_router

Downstream consumer of the input FIFO in the switch datapath. Pops words from the FIFO whenever it is not empty, decodes the destination from the two most-significant data bits, and writes each word into one of four output-lane FIFOs. Honours each lane's pause (almost_full) by holding the word until that lane frees. Keeps a per-lane forwarded-word count for the tester's checks.

## Interface
- DATA_SIZE, 10, data word width; bits [DATA_SIZE-1:DATA_SIZE-2] are the destination lane (0..3)
- CNT_SIZE, 8, width of each per-lane word counter

- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- fifo_empty  input  1  upstream FIFO empty flag
- data_out_pop  input  DATA_SIZE  upstream FIFO read data; valid the cycle after read=1
- read  output  1  pop strobe to upstream FIFO
- lane_pause  input  4  per-lane almost_full of the downstream FIFOs; bit i pauses lane i
- push_data  output  DATA_SIZE  word presented to all lane FIFOs
- push  output  4  one-hot write strobe; bit i writes lane i
- router_active  output  1  high when state is not IDLE
- cnt_lane0..cnt_lane3  output  CNT_SIZE each  words forwarded to each lane

## Operation
- States: IDLE, FETCH, SEND.
- IDLE:
  - read = !fifo_empty.
  - Goes to FETCH if read=1; otherwise stays in IDLE.
- FETCH:
  - read = 0.
  - Captures data_out_pop into the hold register.
  - Goes to SEND unconditionally.
- SEND:
  - dest = hold[DATA_SIZE-1:DATA_SIZE-2].
  - If lane_pause[dest]=0: push[dest]=1 this cycle, and cnt_lane[dest] increments at the clock edge.
  - After a push, if fifo_empty=0 then read=1 in the same cycle and the next state is FETCH (back-to-back). Otherwise the next state is IDLE.
  - If lane_pause[dest]=1: push=0, read=0, stay in SEND, hold unchanged.
- push_data always equals the hold register. push is combinational from state, hold and lane_pause.
- Only lane_pause[dest] matters. Pause on other lanes never stalls the current word.
- Counters:
  - Unsigned, modulo 2^CNT_SIZE; 255 + 1 wraps to 0.
  - No saturation.
  - Only the counter for the lane being pushed changes.
- Reset:
  - State goes to IDLE.
  - hold, push_data and all counters go to 0.
  - read=0, push=0, router_active=0.
- Reset in FETCH or SEND: the in-flight word is discarded, with no push and no count. The upstream FIFO is cleared by the same reset, so no word is duplicated.
- Reset dominates every other input in the same cycle.
- fifo_empty rising in FETCH has no effect; the pop already happened.

## Timing
- Latency:
  - Word present in a previously empty FIFO (fifo_empty low at edge k, state IDLE) gives read high during cycle k.
  - The word is captured at the end of cycle k+1 (FETCH).
  - push is high during cycle k+2 if the lane is not paused.
- Throughput: one word per 2 cycles in steady state (FETCH/SEND alternation); read pulses are never longer than 1 cycle.
- A lane_pause rise or fall takes effect the same cycle (combinational gating); a push is never issued while its lane's pause is high.
- read and push are never both high for the same word; a new read is issued only in the cycle the current word is pushed.
- At most one push bit is high in any cycle.

## Test plan
- Reset then write 0x0A5 (lane 0) upstream -> read high 1 cycle, push=0001 two cycles later with push_data=0x0A5, cnt_lane0=1, router_active back to 0.
- Four words 0x123, 0x2FF, 0x0F0, 0x3AA queued, no pause -> pushes 0010, 0100, 0001, 1000 on alternate cycles, data in order, each counter=1.
- lane_pause=0100 with word 0x201 held -> SEND held, push=0 for the 5 paused cycles; pause drops -> push=0100 that cycle. lane_pause=0001 with a lane-1 word -> no stall.
- Send 256 words to lane 3 -> cnt_lane3 wraps 255 -> 0, other counters stay 0.
- Reset asserted in FETCH, then in SEND with paused lane -> no push, hold/counters 0, state IDLE next cycle; reset held for 3 cycles with fifo_empty=0 -> read stays 0.
- Compare against the synthesized netlist under the same stimulus -> all outputs identical every cycle.
